// File: rtl/riscv_pkg.sv
// Shared definitions for the integer pipeline: datapath width and the ALU
// control codes produced by the control generator and consumed by ex_stage.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;

  // True for the four codes the ALU implements; anything else is illegal.
  function automatic logic alu_ctrl_legal(input logic [ALU_CTRL_W-1:0] ctrl);
    return (ctrl == ALU_ADD) || (ctrl == ALU_SUB) ||
           (ctrl == ALU_AND) || (ctrl == ALU_OR);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: ADD/SUB wrap modulo 2^XLEN, AND/OR bitwise.
// Undefined control codes yield a zero result and raise illegal.
module alu_core #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [3:0]      ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  import riscv_pkg::*;

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = '0;
    endcase
  end

  assign illegal = !alu_ctrl_legal(ctrl);
  assign zero    = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: one ALU operation per accepted transfer, registered into an
// output register backed by a one-entry skid register.
module ex_stage #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      alu_ctrl_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [4:0]      rd_i,
  input  logic            reg_write_i,
  input  logic            branch_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            branch_taken_o,
  output logic            illegal_o,
  output logic [4:0]      rd_o,
  output logic            reg_write_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1 (and no flush); valid never depends on ready, and once raised the
  // bundle is held unchanged until it transfers.

  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            alu_illegal;

  alu_core #(.XLEN(XLEN)) u_alu (
    .ctrl    (alu_ctrl_i),
    .a       (op_a_i),
    .b       (op_b_i),
    .result  (alu_result),
    .zero    (alu_zero),
    .illegal (alu_illegal)
  );

  logic            out_valid_q;
  logic [XLEN-1:0] out_result_q;
  logic            out_zero_q;
  logic            out_taken_q;
  logic            out_illegal_q;
  logic [4:0]      out_rd_q;
  logic            out_reg_write_q;

  logic            skid_valid_q;
  logic [XLEN-1:0] skid_result_q;
  logic            skid_zero_q;
  logic            skid_taken_q;
  logic            skid_illegal_q;
  logic [4:0]      skid_rd_q;
  logic            skid_reg_write_q;

  logic accept;
  logic out_free;
  logic new_taken;

  // in_ready is a pure register copy, so out_ready never reaches it combinationally.
  assign in_ready_o = !skid_valid_q;
  assign accept     = in_valid_i && in_ready_o && !flush_i;
  assign out_free   = !out_valid_q || out_ready_i;
  assign new_taken  = branch_i && alu_zero;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q      <= 1'b0;
      out_result_q     <= '0;
      out_zero_q       <= 1'b0;
      out_taken_q      <= 1'b0;
      out_illegal_q    <= 1'b0;
      out_rd_q         <= '0;
      out_reg_write_q  <= 1'b0;
      skid_valid_q     <= 1'b0;
      skid_result_q    <= '0;
      skid_zero_q      <= 1'b0;
      skid_taken_q     <= 1'b0;
      skid_illegal_q   <= 1'b0;
      skid_rd_q        <= '0;
      skid_reg_write_q <= 1'b0;
    end else if (flush_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q) begin
      // Skid full implies the output register is full and input is stalled.
      if (out_ready_i) begin
        out_result_q    <= skid_result_q;
        out_zero_q      <= skid_zero_q;
        out_taken_q     <= skid_taken_q;
        out_illegal_q   <= skid_illegal_q;
        out_rd_q        <= skid_rd_q;
        out_reg_write_q <= skid_reg_write_q;
        skid_valid_q    <= 1'b0;
      end
    end else if (accept) begin
      if (out_free) begin
        out_valid_q     <= 1'b1;
        out_result_q    <= alu_result;
        out_zero_q      <= alu_zero;
        out_taken_q     <= new_taken;
        out_illegal_q   <= alu_illegal;
        out_rd_q        <= rd_i;
        out_reg_write_q <= reg_write_i;
      end else begin
        skid_valid_q     <= 1'b1;
        skid_result_q    <= alu_result;
        skid_zero_q      <= alu_zero;
        skid_taken_q     <= new_taken;
        skid_illegal_q   <= alu_illegal;
        skid_rd_q        <= rd_i;
        skid_reg_write_q <= reg_write_i;
      end
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o    = out_valid_q;
  assign result_o       = out_result_q;
  assign zero_o         = out_zero_q;
  assign branch_taken_o = out_taken_q;
  assign illegal_o      = out_illegal_q;
  assign rd_o           = out_rd_q;
  assign reg_write_o    = out_reg_write_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU results, branch/illegal flags, skid
// back-pressure, flush and asynchronous reset, with an in-order result queue.
module tb_ex_stage;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd;
  logic            reg_write;
  logic            branch;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            branch_taken;
  logic            illegal;
  logic [4:0]      rd_out;
  logic            reg_write_out;

  int n_vec = 0;
  int n_err = 0;
  logic [XLEN-1:0] exp_q[$];

  ex_stage #(.XLEN(XLEN)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .flush_i        (flush),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .alu_ctrl_i     (alu_ctrl),
    .op_a_i         (op_a),
    .op_b_i         (op_b),
    .rd_i           (rd),
    .reg_write_i    (reg_write),
    .branch_i       (branch),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .result_o       (result),
    .zero_o         (zero),
    .branch_taken_o (branch_taken),
    .illegal_o      (illegal),
    .rd_o           (rd_out),
    .reg_write_o    (reg_write_out)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ctrl, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [4:0] r,
                       input logic rw, input logic br);
    alu_ctrl  = ctrl;
    op_a      = a;
    op_b      = b;
    rd        = r;
    reg_write = rw;
    branch    = br;
    in_valid  = 1'b1;
  endtask

  // Present one op, let it be accepted on the next edge, then go idle.
  task automatic issue(input logic [3:0] ctrl, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [4:0] r,
                       input logic rw, input logic br, input logic [XLEN-1:0] exp);
    drive(ctrl, a, b, r, rw, br);
    exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  // scoreboard: every bundle that transfers downstream is popped in order
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected", 64'd1, 64'd0);
      else check("sb_result", 64'(result), 64'(exp_q.pop_front()));
    end
  end

  task automatic check_all_zero(input string pfx);
    check({pfx, "_out_valid"}, 64'(out_valid), 64'd0);
    check({pfx, "_in_ready"},  64'(in_ready),  64'd1);
    check({pfx, "_result"},    64'(result),    64'd0);
    check({pfx, "_zero"},      64'(zero),      64'd0);
    check({pfx, "_taken"},     64'(branch_taken), 64'd0);
    check({pfx, "_illegal"},   64'(illegal),   64'd0);
    check({pfx, "_rd"},        64'(rd_out),    64'd0);
    check({pfx, "_reg_write"}, 64'(reg_write_out), 64'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    alu_ctrl = 4'b0000;
    op_a = '0;
    op_b = '0;
    rd = '0;
    reg_write = 1'b0;
    branch = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;

    // ADD wraps to zero, visible one cycle after the first post-reset edge
    issue(4'b0010, 32'hFFFF_FFFF, 32'h1, 5'd5, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("add_wrap_valid", 64'(out_valid), 64'd1);
    check("add_wrap_result", 64'(result), 64'd0);
    check("add_wrap_zero", 64'(zero), 64'd1);
    check("add_wrap_rd", 64'(rd_out), 64'd5);
    check("add_wrap_rw", 64'(reg_write_out), 64'd1);
    check("add_wrap_illegal", 64'(illegal), 64'd0);

    issue(4'b0110, 32'd5, 32'd5, 5'd1, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    check("sub_eq_taken", 64'(branch_taken), 64'd1);
    check("sub_eq_zero", 64'(zero), 64'd1);
    check("sub_eq_rw", 64'(reg_write_out), 64'd0);

    issue(4'b0110, 32'd5, 32'd3, 5'd2, 1'b1, 1'b1, 32'h2);
    @(negedge clk);
    check("sub_ne_result", 64'(result), 64'd2);
    check("sub_ne_taken", 64'(branch_taken), 64'd0);
    check("sub_ne_zero", 64'(zero), 64'd0);

    issue(4'b1111, 32'd7, 32'd9, 5'd3, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("illegal_result", 64'(result), 64'd0);
    check("illegal_flag", 64'(illegal), 64'd1);

    // back-pressure: AND lands in output, OR in skid, ADD waits
    tick();
    check("drained_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    drive(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5'd10, 1'b1, 1'b0);
    exp_q.push_back(32'h0000_F000);
    tick();
    drive(4'b0001, 32'h0000_0F0F, 32'h0000_00F0, 5'd11, 1'b1, 1'b0);
    exp_q.push_back(32'h0000_0FFF);
    @(negedge clk);
    check("skid0_in_ready", 64'(in_ready), 64'd1);
    check("skid0_result", 64'(result), 64'h0000_F000);
    tick();
    drive(4'b0010, 32'h0000_0100, 32'h0000_0023, 5'd12, 1'b1, 1'b0);
    exp_q.push_back(32'h0000_0123);
    @(negedge clk);
    check("skid1_in_ready", 64'(in_ready), 64'd0);
    check("skid1_result", 64'(result), 64'h0000_F000);
    check("skid1_rd", 64'(rd_out), 64'd10);
    tick();
    @(negedge clk);
    check("skid2_in_ready", 64'(in_ready), 64'd0);
    check("skid2_hold", 64'(result), 64'h0000_F000);
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("skid3_result", 64'(result), 64'h0000_0FFF);
    check("skid3_in_ready", 64'(in_ready), 64'd1);
    check("skid3_rd", 64'(rd_out), 64'd11);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("skid4_result", 64'(result), 64'h0000_0123);
    check("skid4_rd", 64'(rd_out), 64'd12);
    tick();
    @(negedge clk);
    check("skid5_valid", 64'(out_valid), 64'd0);
    check("skid_queue_empty", 64'(exp_q.size()), 64'd0);

    // flush with output and skid full and a new op waiting
    tick();
    out_ready = 1'b0;
    drive(4'b0000, 32'hF, 32'h3, 5'd4, 1'b1, 1'b0);
    tick();
    drive(4'b0001, 32'h1, 32'h2, 5'd6, 1'b1, 1'b0);
    tick();
    drive(4'b0010, 32'h1, 32'h1, 5'd8, 1'b1, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    check("preflush_valid", 64'(out_valid), 64'd1);
    check("preflush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    tick();
    @(negedge clk);
    check("flush_nothing_accepted", 64'(out_valid), 64'd0);

    // asynchronous reset mid-stream
    tick();
    drive(4'b0000, 32'hA5, 32'hFF, 5'd7, 1'b1, 1'b1);
    tick();
    drive(4'b0001, 32'h10, 32'h01, 5'd9, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("prereset_valid", 64'(out_valid), 64'd1);
    check("prereset_in_ready", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    issue(4'b0010, 32'd2, 32'd3, 5'd13, 1'b1, 1'b0, 32'd5);
    @(negedge clk);
    check("post_reset_valid", 64'(out_valid), 64'd1);
    check("post_reset_result", 64'(result), 64'd5);
    check("post_reset_rd", 64'(rd_out), 64'd13);
    tick();
    @(negedge clk);
    check("final_valid", 64'(out_valid), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
